// File: rtl/layer_mixer_pkg.sv
`default_nettype none
// layer_mixer_pkg: shared RGB width, pair-count macro and pair-index helper for the layer mixer.
`ifndef LAYER_MIXER_DEFS
`define LAYER_MIXER_DEFS
`define MIXER_RGB_W 12
`define MIXER_PAIRS(n) ((n) * ((n) - 1) / 2)
`endif

package layer_mixer_pkg;

  localparam int DEF_RGB_W = `MIXER_RGB_W;

  // Lexicographic index of pair (i,j), i<j: (0,1)=0, (0,2)=1, ...
  function automatic int pair_idx(input int i, input int j, input int layers);
    return i * layers - i * (i + 1) / 2 + (j - i - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mixer_hit_acc.sv
`default_nettype none
// mixer_hit_acc: sticky pairwise-overlap accumulator, latched into o_hit on each v_sync falling edge.
module mixer_hit_acc
  import layer_mixer_pkg::*;
#(
  parameter int LAYERS = 4,
  parameter int PAIRS  = `MIXER_PAIRS(LAYERS)
) (
  input  logic              clk_vga,
  input  logic              rst,
  input  logic              i_v_sync,
  input  logic [LAYERS-1:0] i_alpha,
  output logic [PAIRS-1:0]  o_hit,
  output logic              o_hit_vld
);
  logic             r_vs_s1;
  logic             r_vs_s2;
  logic [PAIRS-1:0] r_acc;
  logic [PAIRS-1:0] r_hit;
  logic             r_hit_vld;
  logic [PAIRS-1:0] w_ov;
  logic             w_fall;

  for (genvar i = 0; i < LAYERS; i++) begin : g_row
    for (genvar j = i + 1; j < LAYERS; j++) begin : g_col
      assign w_ov[pair_idx(i, j, LAYERS)] = i_alpha[i] & i_alpha[j];
    end
  end

  assign w_fall = r_vs_s2 & ~r_vs_s1;

  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      r_vs_s1   <= 1'b1;
      r_vs_s2   <= 1'b1;
      r_acc     <= '0;
      r_hit     <= '0;
      r_hit_vld <= 1'b0;
    end else begin
      r_vs_s1   <= i_v_sync;
      r_vs_s2   <= r_vs_s1;
      r_hit_vld <= w_fall;
      // An overlap on the frame-end cycle itself belongs to the closing frame.
      if (w_fall) begin
        r_hit <= r_acc | w_ov;
        r_acc <= '0;
      end else begin
        r_acc <= r_acc | w_ov;
      end
    end
  end

  assign o_hit     = r_hit;
  assign o_hit_vld = r_hit_vld;

endmodule
`default_nettype wire

// File: rtl/layer_mixer.sv
`default_nettype none
// layer_mixer: N-layer fixed-priority sprite compositor with a 2-cycle pixel pipeline.
// Define MIXER_HIT_EN to compile in per-frame pairwise collision reporting (hit_o/hit_vld_o).
module layer_mixer
  import layer_mixer_pkg::*;
#(
  parameter int               LAYERS = 4,
  parameter int               RGB_W  = DEF_RGB_W,
  parameter logic [RGB_W-1:0] BG_RGB = '0,
  localparam int              PAIRS  = `MIXER_PAIRS(LAYERS),
  localparam int              ID_W   = $clog2(LAYERS)
) (
  input  logic                    clk_vga,
  input  logic                    rst,
  input  logic                    disp_i,
  input  logic                    v_sync_i,
  input  logic [LAYERS-1:0]       layer_en_i,
  input  logic [LAYERS*RGB_W-1:0] layer_rgb_i,
  input  logic [LAYERS-1:0]       layer_alpha_i,
  output logic [RGB_W-1:0]        rgb_o,
  output logic                    alpha_o,
  output logic [ID_W-1:0]         top_id_o,
  output logic                    disp_o,
  output logic [PAIRS-1:0]        hit_o,
  output logic                    hit_vld_o
);
  logic                    r_disp;
  logic [LAYERS*RGB_W-1:0] r_rgb;
  logic [LAYERS-1:0]       r_alpha;
  logic [RGB_W-1:0]        r_rgb_out;
  logic                    r_alpha_out;
  logic [ID_W-1:0]         r_id_out;
  logic                    r_disp_out;
  logic [LAYERS-1:0]       w_win;
  logic [RGB_W-1:0]        w_rgb;
  logic [ID_W-1:0]         w_id;

  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      r_disp  <= 1'b0;
      r_rgb   <= '0;
      r_alpha <= '0;
    end else begin
      r_disp  <= disp_i;
      r_rgb   <= layer_rgb_i;
      r_alpha <= layer_alpha_i & layer_en_i & {LAYERS{disp_i}};
    end
  end

  // One-hot winner: opaque and no higher-priority (lower index) layer opaque.
  for (genvar k = 0; k < LAYERS; k++) begin : g_win
    if (k == 0) begin : g_first
      assign w_win[k] = r_alpha[0];
    end else begin : g_rest
      assign w_win[k] = r_alpha[k] & ~|r_alpha[k-1:0];
    end
  end

  always_comb begin
    w_rgb = r_disp ? BG_RGB : '0;
    w_id  = '0;
    for (int k = 0; k < LAYERS; k++) begin
      if (w_win[k]) begin
        w_rgb = r_rgb[k*RGB_W +: RGB_W];
        w_id  = ID_W'(k);
      end
    end
  end

  always_ff @(posedge clk_vga or negedge rst) begin
    if (!rst) begin
      r_rgb_out   <= '0;
      r_alpha_out <= 1'b0;
      r_id_out    <= '0;
      r_disp_out  <= 1'b0;
    end else begin
      r_rgb_out   <= w_rgb;
      r_alpha_out <= |r_alpha;
      r_id_out    <= w_id;
      r_disp_out  <= r_disp;
    end
  end

  assign rgb_o    = r_rgb_out;
  assign alpha_o  = r_alpha_out;
  assign top_id_o = r_id_out;
  assign disp_o   = r_disp_out;

`ifdef MIXER_HIT_EN
  mixer_hit_acc #(
    .LAYERS (LAYERS),
    .PAIRS  (PAIRS)
  ) u_hit_acc (
    .clk_vga   (clk_vga),
    .rst       (rst),
    .i_v_sync  (v_sync_i),
    .i_alpha   (r_alpha),
    .o_hit     (hit_o),
    .o_hit_vld (hit_vld_o)
  );
`else
  logic w_unused_vsync;
  assign w_unused_vsync = v_sync_i;
  assign hit_o          = '0;
  assign hit_vld_o      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/layer_mixer.md
# layer_mixer

Parametrised N-layer sprite compositor with per-frame collision reporting. It sits between the sprite generators and the VGA output stage, in the same position the fixed four-sprite merge occupies today. It takes LAYERS rgb/alpha streams in fixed priority order and produces one pixel stream, with a 2-cycle pipeline. It also accumulates every pairwise overlap seen during the active frame and reports them as one latched word per frame.

## Interface
Parameters:
- LAYERS, default 4: number of input layers; must be ≥2. Layer 0 has highest priority.
- RGB_W, default 12: colour width per layer, matching the shared RGB depth.
- BG_RGB, default 0: colour output in the active area when no layer is opaque.

Derived: PAIRS = LAYERS*(LAYERS-1)/2; ID_W = $clog2(LAYERS).

Ports:
- clk_vga  in  1  pixel clock; the only clock.
- rst  in  1  asynchronous, active-low reset.
- disp_i  in  1  active-area flag from the display timing.
- v_sync_i  in  1  vertical sync, active-low.
- layer_en_i  in  LAYERS  per-layer enable; a disabled layer is treated as transparent.
- layer_rgb_i  in  LAYERS*RGB_W  layer k occupies bits [k*RGB_W +: RGB_W].
- layer_alpha_i  in  LAYERS  1 = layer k is opaque at this pixel.
- rgb_o  out  RGB_W  composited pixel.
- alpha_o  out  1  at least one layer is opaque.
- top_id_o  out  ID_W  index of the winning layer; 0 when alpha_o=0.
- disp_o  out  1  disp_i delayed to align with rgb_o.
- hit_o  out  PAIRS  collision word for the last completed frame.
- hit_vld_o  out  1  one-cycle pulse when hit_o updates.

## Operation
- Stage 1 registers the inputs:
  - disp_i
  - rgb_i
  - masked alpha a[k] = layer_alpha_i[k] & layer_en_i[k] & disp_i
- Stage 2 selects the pixel:
  - Winner is the lowest k with a[k]=1.
  - rgb_o = rgb of the winner; top_id_o = k; alpha_o = 1.
  - If there is no winner and disp is high: rgb_o = BG_RGB, alpha_o = 0, top_id_o = 0.
  - If disp is low (blanking): rgb_o = 0, regardless of BG_RGB.
- Pair index ordering is lexicographic over (i,j) with i<j. For LAYERS=4: (0,1)=0, (0,2)=1, (0,3)=2, (1,2)=3, (1,3)=4, (2,3)=5.
- Overlap: ov[p] = a[i] & a[j], taken from the stage-1 registers.
- Accumulator acc[PAIRS] is sticky: acc |= ov every cycle.
- Frame end is the falling edge of v_sync_i, detected against a registered copy of v_sync_i. On that cycle:
  - hit_o <= acc | ov (an overlap in the same cycle is included).
  - acc <= 0.
  - hit_vld_o = 1 for one cycle.
- hit_o holds its value between pulses.
- Disabled layers never contribute to collisions.
- Reset mid-frame clears acc and hit_o. The first report after reset covers only the partial frame.

## Timing
- Reset values: rgb_o=0, alpha_o=0, top_id_o=0, disp_o=0, hit_o=0, hit_vld_o=0, acc=0, v_sync register=1.
- rgb_o, alpha_o, top_id_o and disp_o follow the inputs by exactly 2 clk_vga cycles.
- v_sync_i is sampled in the same stage as the stage-1 inputs. hit_vld_o is asserted 2 cycles after the v_sync_i 1→0 input edge.
- Holding v_sync_i low produces only one pulse. A new pulse needs a 0→1→0 sequence.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- MIXER_HIT_EN defined: the collision accumulator and reporting are compiled in.
- MIXER_HIT_EN undefined:
  - acc and edge logic are removed.
  - hit_o is tied to 0 and hit_vld_o is tied to 0.
  - The pixel path is unchanged.

## Structure
- Shared header holds:
  - the RGB width define (RGB_W default)
  - a PAIRS macro
  - a pair-index function f(i,j) = i*LAYERS - i*(i+1)/2 + (j-i-1)
- Sub-module mixer_hit_acc holds the v_sync edge detector, the acc register and the hit_o/hit_vld_o registers. It is instantiated under MIXER_HIT_EN.
- The priority select is a generate-loop in layer_mixer.

## Test plan
- Reset: assert rst=0 mid-stream -> all outputs 0 immediately. After release with disp_i=0, rgb_o=0 and disp_o=0.
- Priority: LAYERS=4, disp_i=1, all alpha=1, rgb k=0x100*(k+1) -> 2 cycles later rgb_o=0x100, top_id_o=0. Drop alpha[0] -> rgb_o=0x200, top_id_o=1.
- Enable mask and background:
  - BG_RGB=0x0F0, alpha=0b0001, layer_en=0b1110 -> rgb_o=0x0F0, alpha_o=0.
  - Same stimulus with disp_i=0 -> rgb_o=0x000.
- Collisions: one pixel with layers 1 and 3 opaque, then one with layers 0 and 2, then v_sync_i falls -> hit_vld_o single pulse 2 cycles after the edge, hit_o=6'b010010. The next frame with no overlaps -> hit_o=0.
- Simultaneous event and long sync: overlap (2,3) on the exact v_sync_i falling cycle -> included in the reported hit_o (bit 5). Holding v_sync_i low for 100 cycles -> only one pulse.
- Build without MIXER_HIT_EN and rerun the collision scenario -> hit_o=0 and hit_vld_o never asserted; pixel outputs identical to the build with the macro.
